// File: rtl/axis_adc_acq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// axis_adc_acq_ctrl_pkg
// Shared definitions for the triggered ADC acquisition controller:
//   - acq_state_e : FSM state encoding (IDLE/ARMED/DELAY/CAPTURE/DRAIN)
//   - CH_SLICE_W  : bits taken from each ADC channel into a packed beat
//   - DECIM_W     : width of the decimation ratio
//   - decim_eff() : maps a decimation ratio of 0 onto 1
// ---------------------------------------------------------------------------
package axis_adc_acq_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_DELAY   = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DRAIN   = 3'd4
   } acq_state_e;

   localparam int CH_SLICE_W = 16;
   localparam int DECIM_W    = 16;

   // A ratio of zero has no meaning, so it behaves as "keep every sample".
   function automatic logic [DECIM_W-1:0] decim_eff(input logic [DECIM_W-1:0] n);
      logic [DECIM_W-1:0] r;
      if (n == 16'd0) begin
         r = 16'd1;
      end else begin
         r = n;
      end
      return r;
   endfunction

endpackage

// File: rtl/axis_adc_acq_ctrl_decim.sv
// ---------------------------------------------------------------------------
// acq_decim_cnt
// Decimation phase counter. Counts qualifying samples modulo the decimation
// ratio and strobes keep on the first sample of every group of N.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   clr      : holds the phase at zero (asserted whenever not capturing)
//   en       : a qualifying sample is present this cycle
//   decim    : latched decimation ratio (0 behaves as 1)
//   keep     : this cycle's qualifying sample is kept
// ---------------------------------------------------------------------------
module acq_decim_cnt
   import axis_adc_acq_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic [DECIM_W-1:0] decim,
   output logic               keep
);

   logic [DECIM_W-1:0] phase_q;
   logic [DECIM_W-1:0] phase_d;
   logic [DECIM_W-1:0] last_phase_s;

   assign last_phase_s = decim_eff(decim) - 16'd1;
   assign keep         = en & ~clr & (phase_q == 16'd0);

   // Next phase: wraps to zero after N qualifying samples.
   always_comb begin
      phase_d = phase_q;
      if (clr) begin
         phase_d = 16'd0;
      end else if (en) begin
         if (phase_q >= last_phase_s) begin
            phase_d = 16'd0;
         end else begin
            phase_d = phase_q + 16'd1;
         end
      end else begin
         phase_d = phase_q;
      end
   end

   // Phase register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= 16'd0;
      end else begin
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/axis_adc_acq_ctrl.sv
// ---------------------------------------------------------------------------
// axis_adc_acq_ctrl
// Triggered two-channel ADC acquisition controller. After an arm pulse the
// block waits for a rising trigger edge, waits cfg_delay cycles, then packs
// decimated sample pairs {ch B[15:0], ch A[15:0]} onto an AXI-Stream output
// until cfg_samples beats have been produced; the final beat carries tlast.
// Ports:
//   aclk, areset              : clock, asynchronous active-high reset
//   cfg_delay/samples/decim   : acquisition setup, latched on arm
//   arm, abort, trigger       : control (arm pulse, abort level, trigger level)
//   s0_axis_*, s1_axis_*      : ADC channel A / B input streams
//   m_axis_*                  : packed capture stream
//   sts_busy/overflow/count   : status (not idle / sticky drop / kept samples)
// ---------------------------------------------------------------------------
module axis_adc_acq_ctrl #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int CNTR_WIDTH       = 32
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic [CNTR_WIDTH-1:0]       cfg_delay,
   input  logic [CNTR_WIDTH-1:0]       cfg_samples,
   input  logic [15:0]                 cfg_decim,
   input  logic                        arm,
   input  logic                        abort,
   input  logic                        trigger,
   input  logic                        s0_axis_tvalid,
   input  logic [AXIS_TDATA_WIDTH-1:0] s0_axis_tdata,
   input  logic                        s1_axis_tvalid,
   input  logic [AXIS_TDATA_WIDTH-1:0] s1_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        sts_busy,
   output logic                        sts_overflow,
   output logic [CNTR_WIDTH-1:0]       sts_count
);
   import axis_adc_acq_ctrl_pkg::*;

   acq_state_e state_q, state_d;

   logic [CNTR_WIDTH-1:0]       delay_q, delay_d;
   logic [CNTR_WIDTH-1:0]       samples_q, samples_d;
   logic [DECIM_W-1:0]          decim_q, decim_d;
   logic [CNTR_WIDTH-1:0]       dcnt_q, dcnt_d;
   logic [CNTR_WIDTH-1:0]       count_q, count_d;
   logic                        trig_q, trig_d;
   logic                        tvalid_q, tvalid_d;
   logic                        tlast_q, tlast_d;
   logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                        busy_q, busy_d;
   logic                        ovf_q, ovf_d;

   logic                        trig_edge_s;
   logic                        in_capture_s;
   logic                        qual_s;
   logic                        keep_s;
   logic                        take_s;
   logic                        final_s;
   logic                        stall_s;
   logic [CNTR_WIDTH-1:0]       count_inc_s;
   logic [2*CH_SLICE_W-1:0]     pair_s;
   logic [AXIS_TDATA_WIDTH-1:0] packed_s;
   logic                        unused_upper_s;

   // Only the low slice of each (sign-extended) channel is packed.
   assign unused_upper_s = ^{s0_axis_tdata[AXIS_TDATA_WIDTH-1:CH_SLICE_W],
                             s1_axis_tdata[AXIS_TDATA_WIDTH-1:CH_SLICE_W]};
   assign pair_s   = {s1_axis_tdata[CH_SLICE_W-1:0], s0_axis_tdata[CH_SLICE_W-1:0]};
   assign packed_s = AXIS_TDATA_WIDTH'(pair_s);

   assign trig_edge_s  = trigger & ~trig_q;
   assign in_capture_s = (state_q == ST_CAPTURE);
   assign qual_s       = in_capture_s & s0_axis_tvalid & s1_axis_tvalid;
   // Sample count saturates rather than wrapping.
   assign count_inc_s  = (count_q == {CNTR_WIDTH{1'b1}}) ? count_q : count_q + CNTR_WIDTH'(1);
   // A kept sample only counts when the acquisition wants any beats at all.
   assign take_s       = keep_s & (samples_q != CNTR_WIDTH'(0));
   assign final_s      = take_s & (count_inc_s == samples_q);
   // Output register still holds an unaccepted beat.
   assign stall_s      = tvalid_q & ~m_axis_tready;

   acq_decim_cnt u_decim (
      .clk   (aclk),
      .rst   (areset),
      .clr   (~in_capture_s),
      .en    (qual_s),
      .decim (decim_q),
      .keep  (keep_s)
   );

   // FSM state register.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; abort overrides everything.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (arm) begin
                  state_d = ST_ARMED;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ARMED: begin
               if (trig_edge_s) begin
                  state_d = (delay_q == CNTR_WIDTH'(0)) ? ST_CAPTURE : ST_DELAY;
               end else begin
                  state_d = ST_ARMED;
               end
            end
            ST_DELAY: begin
               if (dcnt_q <= CNTR_WIDTH'(1)) begin
                  state_d = ST_CAPTURE;
               end else begin
                  state_d = ST_DELAY;
               end
            end
            ST_CAPTURE: begin
               if (samples_q == CNTR_WIDTH'(0)) begin
                  state_d = ST_IDLE;
               end else if (final_s) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_CAPTURE;
               end
            end
            ST_DRAIN: begin
               if (!tvalid_q || m_axis_tready) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Output/datapath next values: config latch, counters, beat register.
   always_comb begin
      trig_d    = trigger;
      delay_d   = delay_q;
      samples_d = samples_q;
      decim_d   = decim_q;
      dcnt_d    = dcnt_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      tdata_d   = tdata_q;
      busy_d    = (state_d != ST_IDLE);
      // An accepted beat leaves the register unless replaced below.
      if (tvalid_q && m_axis_tready) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end else begin
         tvalid_d = tvalid_q;
         tlast_d  = tlast_q;
      end
      if (abort) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (arm) begin
                  delay_d   = cfg_delay;
                  samples_d = cfg_samples;
                  decim_d   = cfg_decim;
                  count_d   = CNTR_WIDTH'(0);
                  ovf_d     = 1'b0;
               end else begin
                  count_d   = count_q;
               end
            end
            ST_ARMED: begin
               if (trig_edge_s) begin
                  dcnt_d = delay_q;
               end else begin
                  dcnt_d = dcnt_q;
               end
            end
            ST_DELAY: begin
               if (dcnt_q != CNTR_WIDTH'(0)) begin
                  dcnt_d = dcnt_q - CNTR_WIDTH'(1);
               end else begin
                  dcnt_d = dcnt_q;
               end
            end
            ST_CAPTURE: begin
               if (take_s) begin
                  count_d = count_inc_s;
                  if (stall_s) begin
                     // Drop the new sample; a dropped final sample promotes
                     // the held beat to the last one.
                     ovf_d   = 1'b1;
                     tlast_d = final_s ? 1'b1 : tlast_q;
                  end else begin
                     tvalid_d = 1'b1;
                     tdata_d  = packed_s;
                     tlast_d  = final_s;
                  end
               end else begin
                  count_d = count_q;
               end
            end
            ST_DRAIN: begin
               tdata_d = tdata_q;
            end
            default: begin
               tdata_d = tdata_q;
            end
         endcase
      end
   end

   // Datapath and status registers.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         delay_q   <= {CNTR_WIDTH{1'b0}};
         samples_q <= {CNTR_WIDTH{1'b0}};
         decim_q   <= 16'd0;
         dcnt_q    <= {CNTR_WIDTH{1'b0}};
         count_q   <= {CNTR_WIDTH{1'b0}};
         trig_q    <= 1'b0;
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
         tdata_q   <= {AXIS_TDATA_WIDTH{1'b0}};
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         delay_q   <= delay_d;
         samples_q <= samples_d;
         decim_q   <= decim_d;
         dcnt_q    <= dcnt_d;
         count_q   <= count_d;
         trig_q    <= trig_d;
         tvalid_q  <= tvalid_d;
         tlast_q   <= tlast_d;
         tdata_q   <= tdata_d;
         busy_q    <= busy_d;
         ovf_q     <= ovf_d;
      end
   end

   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tdata  = tdata_q;
   assign sts_busy      = busy_q;
   assign sts_overflow  = ovf_q;
   assign sts_count     = count_q;

endmodule

// File: tb/tb_axis_adc_acq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axis_adc_acq_ctrl
// Scoreboard bench: acquisition tasks compute the expected beats (data, tlast
// and the cycle they must appear in) from the trigger/delay/decimation rules
// and queue them; an independent monitor compares every accepted beat.
// ---------------------------------------------------------------------------
module tb_axis_adc_acq_ctrl;
   localparam int DW = 32;
   localparam int CW = 32;

   logic          aclk;
   logic          areset;
   logic [CW-1:0] cfg_delay;
   logic [CW-1:0] cfg_samples;
   logic [15:0]   cfg_decim;
   logic          arm;
   logic          abort;
   logic          trigger;
   logic          s0_axis_tvalid;
   logic [DW-1:0] s0_axis_tdata;
   logic          s1_axis_tvalid;
   logic [DW-1:0] s1_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic [DW-1:0] m_axis_tdata;
   logic          sts_busy;
   logic          sts_overflow;
   logic [CW-1:0] sts_count;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [31:0] data;
      logic        last;
      int          cyc;   // -1: any cycle
   } beat_t;

   beat_t sb_q[$];
   beat_t mon_b;

   axis_adc_acq_ctrl #(.AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW)) dut (
      .aclk           (aclk),
      .areset         (areset),
      .cfg_delay      (cfg_delay),
      .cfg_samples    (cfg_samples),
      .cfg_decim      (cfg_decim),
      .arm            (arm),
      .abort          (abort),
      .trigger        (trigger),
      .s0_axis_tvalid (s0_axis_tvalid),
      .s0_axis_tdata  (s0_axis_tdata),
      .s1_axis_tvalid (s1_axis_tvalid),
      .s1_axis_tdata  (s1_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_tdata   (m_axis_tdata),
      .sts_busy       (sts_busy),
      .sts_overflow   (sts_overflow),
      .sts_count      (sts_count)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted beat must match the head of the scoreboard.
   always @(negedge aclk) begin
      if (!areset && m_axis_tvalid && m_axis_tready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_axis_tdata);
         end else begin
            mon_b = sb_q.pop_front();
            check("beat_data", m_axis_tdata, mon_b.data);
            check("beat_last", m_axis_tlast, mon_b.last);
            if (mon_b.cyc >= 0) check("beat_cycle", cyc, mon_b.cyc);
         end
      end
   end

   task automatic drive_adc(input int vprob);
      s0_axis_tvalid = ($urandom_range(0, 99) < vprob);
      s1_axis_tvalid = ($urandom_range(0, 99) < vprob);
      s0_axis_tdata  = $urandom;
      s1_axis_tdata  = $urandom;
   endtask

   // One full acquisition with tready held high. The capture window opens
   // delay+1 cycles after the trigger cycle; qualifying samples 0, N, 2N...
   // are kept and appear one cycle later.
   task automatic run_acq(input int dly, input int nsamp, input int dec, input int vprob);
      int neff;
      int cap_k;
      int qual;
      int kept;
      int last_k;
      bit done;
      bit arm_ok;
      neff   = (dec == 0) ? 1 : dec;
      cap_k  = 1 + dly;
      qual   = 0;
      kept   = 0;
      last_k = -1;
      done   = 1'b0;
      m_axis_tready = 1'b1;
      @(posedge aclk); #1;
      arm = 1'b1; trigger = 1'b0;
      cfg_delay = dly; cfg_samples = nsamp; cfg_decim = 16'(dec);
      drive_adc(vprob);
      @(posedge aclk); #1;
      arm = 1'b0; trigger = 1'b1;
      cfg_delay = $urandom_range(0, 50); cfg_samples = $urandom_range(0, 9);
      cfg_decim = 16'($urandom_range(0, 5));
      drive_adc(vprob);
      for (int k = 1; k < 3000 && !done; k++) begin
         @(posedge aclk); #1;
         drive_adc(vprob);
         trigger = 1'($urandom_range(0, 1));
         cfg_delay = $urandom_range(0, 50); cfg_samples = $urandom_range(0, 9);
         arm_ok = (k <= cap_k) || (kept < nsamp);
         arm = arm_ok && ($urandom_range(0, 7) == 0);
         if (k >= cap_k && kept < nsamp && s0_axis_tvalid && s1_axis_tvalid) begin
            if (qual % neff == 0) begin
               sb_q.push_back('{data: {s1_axis_tdata[15:0], s0_axis_tdata[15:0]},
                                last: (kept + 1 == nsamp), cyc: cyc + 1});
               kept++;
               if (kept == nsamp) last_k = k;
            end
            qual++;
         end
         @(negedge aclk);
         if (k == cap_k) check("capture_busy", sts_busy, 1'b1);
         if (nsamp == 0 && k == cap_k + 1) begin
            check("zero_samples_idle", sts_busy, 1'b0);
            done = 1'b1;
         end
         if (last_k >= 0 && k == last_k + 1) check("drain_busy", sts_busy, 1'b1);
         if (last_k >= 0 && k == last_k + 2) begin
            check("end_idle", sts_busy, 1'b0);
            done = 1'b1;
         end
      end
      arm = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL acq_timeout: got no return to idle, expected idle after %0d beats", nsamp);
      end
      check("end_count", sts_count, nsamp);
      check("end_overflow", sts_overflow, 1'b0);
      check("sb_empty", sb_q.size(), 0);
   endtask

   // Backpressure for the whole capture: first beat held, rest dropped.
   task automatic overflow_test();
      logic [31:0] first;
      first = 32'd0;
      @(posedge aclk); #1;
      arm = 1'b1; trigger = 1'b0; cfg_delay = 0; cfg_samples = 4; cfg_decim = 16'd1;
      drive_adc(100);
      @(posedge aclk); #1;
      arm = 1'b0; trigger = 1'b1; m_axis_tready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(posedge aclk); #1;
         drive_adc(100);
         if (k == 1) first = {s1_axis_tdata[15:0], s0_axis_tdata[15:0]};
      end
      @(negedge aclk);
      check("ovf_tvalid", m_axis_tvalid, 1'b1);
      check("ovf_tlast", m_axis_tlast, 1'b1);
      check("ovf_tdata", m_axis_tdata, first);
      check("ovf_flag", sts_overflow, 1'b1);
      check("ovf_count", sts_count, 4);
      check("ovf_busy", sts_busy, 1'b1);
      sb_q.push_back('{data: first, last: 1'b1, cyc: -1});
      @(posedge aclk); #1; m_axis_tready = 1'b1;
      @(posedge aclk); #1;
      @(negedge aclk);
      check("ovf_idle", sts_busy, 1'b0);
      check("ovf_tvalid_after", m_axis_tvalid, 1'b0);
      check("ovf_sb_empty", sb_q.size(), 0);
   endtask

   task automatic abort_test();
      // abort while counting down
      @(posedge aclk); #1;
      arm = 1'b1; trigger = 1'b0; cfg_delay = 20; cfg_samples = 3; cfg_decim = 16'd1;
      @(posedge aclk); #1; arm = 1'b0; trigger = 1'b1;
      repeat (3) @(posedge aclk);
      #1 abort = 1'b1;
      @(posedge aclk); #1 abort = 1'b0;
      @(negedge aclk);
      check("abort_delay_busy", sts_busy, 1'b0);
      check("abort_delay_tvalid", m_axis_tvalid, 1'b0);
      // abort with a pending beat, arm high at the same time
      @(posedge aclk); #1;
      arm = 1'b1; trigger = 1'b0; cfg_delay = 0; cfg_samples = 4;
      m_axis_tready = 1'b0; drive_adc(100);
      @(posedge aclk); #1; arm = 1'b0; trigger = 1'b1;
      @(posedge aclk); #1; drive_adc(100);
      @(posedge aclk); #1; drive_adc(100);
      @(negedge aclk);
      check("abort_pending_tvalid", m_axis_tvalid, 1'b1);
      @(posedge aclk); #1; abort = 1'b1; arm = 1'b1;
      @(posedge aclk); #1; abort = 1'b0; arm = 1'b0;
      @(negedge aclk);
      check("abort_pend_busy", sts_busy, 1'b0);
      check("abort_pend_tvalid", m_axis_tvalid, 1'b0);
      check("abort_pend_tlast", m_axis_tlast, 1'b0);
      // arm together with abort while idle
      @(posedge aclk); #1; arm = 1'b1; abort = 1'b1;
      @(posedge aclk); #1; arm = 1'b0; abort = 1'b0;
      @(negedge aclk);
      check("arm_abort_idle", sts_busy, 1'b0);
      m_axis_tready = 1'b1;
   endtask

   task automatic reset_test();
      @(posedge aclk); #1;
      arm = 1'b1; trigger = 1'b0; cfg_delay = 2; cfg_samples = 5; cfg_decim = 16'd1;
      m_axis_tready = 1'b0; drive_adc(100);
      @(posedge aclk); #1; arm = 1'b0; trigger = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge aclk); #1;
         drive_adc(100);
      end
      check("pre_reset_tvalid", m_axis_tvalid, 1'b1);
      #1 areset = 1'b1;
      #1;
      check("rst_tvalid", m_axis_tvalid, 1'b0);
      check("rst_tlast", m_axis_tlast, 1'b0);
      check("rst_tdata", m_axis_tdata, 32'd0);
      check("rst_busy", sts_busy, 1'b0);
      check("rst_overflow", sts_overflow, 1'b0);
      check("rst_count", sts_count, 32'd0);
      repeat (2) @(posedge aclk);
      #1 areset = 1'b0; m_axis_tready = 1'b1;
   endtask

   initial begin
      areset = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
      cfg_delay = '0; cfg_samples = '0; cfg_decim = 16'd0;
      s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
      s0_axis_tdata = '0; s1_axis_tdata = '0; m_axis_tready = 1'b1;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("reset_tvalid", m_axis_tvalid, 1'b0);
      check("reset_tlast", m_axis_tlast, 1'b0);
      check("reset_tdata", m_axis_tdata, 32'd0);
      check("reset_busy", sts_busy, 1'b0);
      check("reset_overflow", sts_overflow, 1'b0);
      check("reset_count", sts_count, 32'd0);
      @(posedge aclk); #1 areset = 1'b0;
      // trigger edges while idle do nothing
      for (int i = 0; i < 4; i++) begin
         @(posedge aclk); #1 trigger = i[0];
         @(negedge aclk);
         check("idle_trigger_busy", sts_busy, 1'b0);
      end
      trigger = 1'b0;
      run_acq(4, 3, 1, 100);
      run_acq($urandom_range(0, 5), 2, 3, 100);
      run_acq(2, 0, 2, 80);
      run_acq(0, 1, 0, 70);
      run_acq(1, 1, 1, 100);
      overflow_test();
      run_acq(1, 2, 1, 100);
      abort_test();
      run_acq(0, 3, 2, 90);
      reset_test();
      run_acq(3, 4, 1, 100);
      for (int r = 0; r < 14; r++) begin
         run_acq($urandom_range(0, 8), $urandom_range(0, 6),
                 $urandom_range(0, 4), $urandom_range(40, 100));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
